// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace buffer: state encoding, record layout, default widths.
// Optional build macro used by pipe_trace_buffer: PIPE_TRACE_WB_FILTER_EN.
package pipe_trace_pkg;

    localparam int W    = 16;
    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_ARMED  = 2'd1,
        TR_POST   = 2'd2,
        TR_FROZEN = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [W-1:0]    instr;
        logic [W-1:0]    wd;
        logic [2:0]      flags;
    } trace_rec_t;

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// Trace storage: DEPTH records, one synchronous write port, one asynchronous read port.
module trace_ram #(
    parameter int  DEPTH = 16,
    parameter type rec_t = pipe_trace_pkg::trace_rec_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  rec_t          wr_data,
    input  logic [AW-1:0] rd_addr,
    output rec_t          rd_data
);

    rec_t mem [DEPTH];

    // NOTE: storage has no reset; the pointers and count alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Debug trace buffer for the five-stage core: arm, trigger on PC match or external strobe,
// capture POST_TRIG further records, freeze, then drain oldest-first over valid/ready.
// Build macro PIPE_TRACE_WB_FILTER_EN restricts capture to records that write a register.
module pipe_trace_buffer #(
    parameter int W         = pipe_trace_pkg::W,
    parameter int PC_W      = pipe_trace_pkg::PC_W,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       cap_valid,
    input  logic                       cap_wb_en,
    input  logic [PC_W-1:0]            cap_pc,
    input  logic [W-1:0]               cap_instr,
    input  logic [W-1:0]               cap_wd,
    input  logic [2:0]                 cap_flags,
    input  logic [PC_W-1:0]            trig_pc,
    input  logic                       trig_ext,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [PC_W-1:0]            rd_pc,
    output logic [W-1:0]               rd_instr,
    output logic [W-1:0]               rd_wd,
    output logic [2:0]                 rd_flags,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [1:0]                 state,
    output logic                       overflow
);

    import pipe_trace_pkg::trace_state_e;
    import pipe_trace_pkg::TR_IDLE;
    import pipe_trace_pkg::TR_ARMED;
    import pipe_trace_pkg::TR_POST;
    import pipe_trace_pkg::TR_FROZEN;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_TRIG);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [W-1:0]    instr;
        logic [W-1:0]    wd;
        logic [2:0]      flags;
    } rec_t;

    trace_state_e  state_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] post_next;
    logic          cap_ok;
    logic          accept;
    logic          hit;
    logic          pop;
    rec_t          wr_rec;
    rec_t          rd_rec;

`ifdef PIPE_TRACE_WB_FILTER_EN
    assign cap_ok = cap_valid && cap_wb_en;
`else
    logic unused_wb_en;
    assign unused_wb_en = cap_wb_en;
    assign cap_ok       = cap_valid;
`endif

    assign accept    = cap_ok && ((state_q == TR_ARMED) || (state_q == TR_POST));
    assign hit       = (cap_pc == trig_pc) || trig_ext;
    assign post_next = post_cnt + AW'(1);
    assign rd_valid  = (state_q == TR_FROZEN) && (count != '0);
    assign pop       = rd_valid && rd_ready;

    assign wr_rec = '{pc: cap_pc, instr: cap_instr, wd: cap_wd, flags: cap_flags};

    // arm wins over a same-cycle capture, so the write port is gated by it too.
    trace_ram #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_ram (
        .clk     (clk),
        .we      (accept && !arm),
        .wr_addr (wr_ptr),
        .wr_data (wr_rec),
        .rd_addr (rd_ptr),
        .rd_data (rd_rec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= TR_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            post_cnt <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (arm) begin
            state_q  <= TR_ARMED;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            post_cnt <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge values.
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (count == FULL) begin
                    rd_ptr   <= rd_ptr + AW'(1);
                    overflow <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end
            case (state_q)
                TR_ARMED: begin
                    if (accept && hit) begin
                        post_cnt <= '0;
                        state_q  <= (POST_TRIG == 0) ? TR_FROZEN : TR_POST;
                    end
                end
                TR_POST: begin
                    if (accept) begin
                        post_cnt <= post_next;
                        if (post_next == POST_LAST) begin
                            state_q <= TR_FROZEN;
                        end
                    end
                end
                TR_FROZEN: begin
                    if (pop) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        count  <= count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign state    = state_q;
    assign rd_pc    = rd_valid ? rd_rec.pc    : '0;
    assign rd_instr = rd_valid ? rd_rec.instr : '0;
    assign rd_wd    = rd_valid ? rd_rec.wd    : '0;
    assign rd_flags = rd_valid ? rd_rec.flags : '0;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: DEPTH=4 with POST_TRIG=2 (dut) and POST_TRIG=0 (dut_z).
module tb_pipe_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arm = 1'b0;
    logic        cap_valid = 1'b0;
    logic        cap_wb_en = 1'b0;
    logic [31:0] cap_pc = '0;
    logic [15:0] cap_instr = '0;
    logic [15:0] cap_wd = '0;
    logic [2:0]  cap_flags = '0;
    logic [31:0] trig_pc = 32'h14;
    logic        trig_ext = 1'b0;
    logic        rd_ready = 1'b0;

    logic        rd_valid,   z_rd_valid;
    logic [31:0] rd_pc,      z_rd_pc;
    logic [15:0] rd_instr,   z_rd_instr;
    logic [15:0] rd_wd,      z_rd_wd;
    logic [2:0]  rd_flags,   z_rd_flags;
    logic [2:0]  count,      z_count;
    logic [1:0]  state,      z_state;
    logic        overflow,   z_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_trace_buffer #(.W(16), .PC_W(32), .DEPTH(4), .POST_TRIG(2)) dut (
        .clk(clk), .rst(rst), .arm(arm), .cap_valid(cap_valid), .cap_wb_en(cap_wb_en),
        .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_wd(cap_wd), .cap_flags(cap_flags),
        .trig_pc(trig_pc), .trig_ext(trig_ext), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_wd(rd_wd),
        .rd_flags(rd_flags), .count(count), .state(state), .overflow(overflow)
    );

    pipe_trace_buffer #(.W(16), .PC_W(32), .DEPTH(4), .POST_TRIG(0)) dut_z (
        .clk(clk), .rst(rst), .arm(arm), .cap_valid(cap_valid), .cap_wb_en(cap_wb_en),
        .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_wd(cap_wd), .cap_flags(cap_flags),
        .trig_pc(trig_pc), .trig_ext(trig_ext), .rd_ready(rd_ready),
        .rd_valid(z_rd_valid), .rd_pc(z_rd_pc), .rd_instr(z_rd_instr), .rd_wd(z_rd_wd),
        .rd_flags(z_rd_flags), .count(z_count), .state(z_state), .overflow(z_overflow)
    );

    function automatic logic [15:0] exp_instr(input logic [31:0] pc);
        return pc[15:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [15:0] exp_wd(input logic [31:0] pc);
        return pc[15:0] + 16'h0100;
    endfunction

    function automatic logic [2:0] exp_flags(input logic [31:0] pc);
        return pc[3:1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic capture(input logic [31:0] pc, input logic wb, input logic ext);
        cap_valid = 1'b1;
        cap_wb_en = wb;
        trig_ext  = ext;
        cap_pc    = pc;
        cap_instr = exp_instr(pc);
        cap_wd    = exp_wd(pc);
        cap_flags = exp_flags(pc);
        tick();
        cap_valid = 1'b0;
        cap_wb_en = 1'b0;
        trig_ext  = 1'b0;
    endtask

    // Arms, then captures 0x10..0x18 with trigger at 0x14: one entry is lost to the wrap.
    task automatic setup_overflow_capture();
        trig_pc = 32'h14;
        do_arm();
        for (int i = 0; i < 5; i++) capture(32'h10 + 32'(2 * i), 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        tests_run++;
        if (state !== 2'd0 || count !== 3'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || rd_pc !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_values: state=%0d count=%0d rd_valid=%b ovf=%b rd_pc=%h, want 0 0 0 0 0",
                     state, count, rd_valid, overflow, rd_pc);
        end
        capture(32'h14, 1'b1, 1'b1);
        tests_run++;
        if (state !== 2'd0 || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL idle_ignores_capture: state=%0d count=%0d, want 0 0", state, count);
        end
    endtask

    task automatic test_capture_overflow();
        trig_pc = 32'h14;
        do_arm();
        tests_run++;
        if (state !== 2'd1 || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL arm_state: state=%0d count=%0d, want 1 0", state, count);
        end
        for (int i = 0; i < 3; i++) capture(32'h10 + 32'(2 * i), 1'b1, 1'b0);
        tests_run++;
        if (state !== 2'd2 || count !== 3'd3 || rd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_after_trigger: state=%0d count=%0d rd_valid=%b, want 2 3 0", state, count, rd_valid);
        end
        capture(32'h16, 1'b1, 1'b0);
        tests_run++;
        if (state !== 2'd2 || count !== 3'd4 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_one_more: state=%0d count=%0d ovf=%b, want 2 4 0", state, count, overflow);
        end
        capture(32'h18, 1'b1, 1'b0);
        tests_run++;
        if (state !== 2'd3 || count !== 3'd4 || overflow !== 1'b1 || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL frozen_overflow: state=%0d count=%0d ovf=%b rd_valid=%b, want 3 4 1 1",
                     state, count, overflow, rd_valid);
        end
        capture(32'h1A, 1'b1, 1'b0);
        tests_run++;
        if (count !== 3'd4 || rd_pc !== 32'h12) begin
            tests_failed++;
            $display("FAIL frozen_no_capture: count=%0d rd_pc=%h, want 4 00000012", count, rd_pc);
        end
    endtask

    task automatic test_read_stall();
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (rd_pc !== 32'h12 || count !== 3'd4 || rd_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: rd_pc=%h count=%0d rd_valid=%b, want 00000012 4 1",
                         i, rd_pc, count, rd_valid);
            end
        end
        tests_run++;
        if (rd_instr !== exp_instr(32'h12) || rd_wd !== exp_wd(32'h12) || rd_flags !== exp_flags(32'h12)) begin
            tests_failed++;
            $display("FAIL entry_fields: instr=%h wd=%h flags=%b, want %h %h %b", rd_instr, rd_wd, rd_flags,
                     exp_instr(32'h12), exp_wd(32'h12), exp_flags(32'h12));
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        tick();
        tests_run++;
        if (rd_pc !== 32'h14 || count !== 3'd3) begin
            tests_failed++;
            $display("FAIL ready_pulse: rd_pc=%h count=%0d, want 00000014 3", rd_pc, count);
        end
    endtask

    task automatic test_readout_order();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'h14, 32'h16, 32'h18};
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rd_valid !== 1'b1 || rd_pc !== exp_pc[i] || count !== 3'(3 - i)) begin
                tests_failed++;
                $display("FAIL readout[%0d]: rd_valid=%b rd_pc=%h count=%0d, want 1 %h %0d",
                         i, rd_valid, rd_pc, count, exp_pc[i], 3 - i);
            end
            tick();
        end
        rd_ready = 1'b0;
        tests_run++;
        if (rd_valid !== 1'b0 || count !== 3'd0 || state !== 2'd3 || rd_pc !== 32'd0) begin
            tests_failed++;
            $display("FAIL drained: rd_valid=%b count=%0d state=%0d rd_pc=%h, want 0 0 3 0",
                     rd_valid, count, state, rd_pc);
        end
    endtask

    task automatic test_reset_mid_frozen();
        setup_overflow_capture();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        tests_run++;
        if (state !== 2'd3 || count !== 3'd3 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: state=%0d count=%0d ovf=%b, want 3 3 1", state, count, overflow);
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (state !== 2'd0 || count !== 3'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: state=%0d count=%0d rd_valid=%b ovf=%b, want 0 0 0 0",
                     state, count, rd_valid, overflow);
        end
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_trigger_first();
        trig_pc = 32'h20;
        do_arm();
        capture(32'h20, 1'b1, 1'b0);
        tests_run++;
        if (z_state !== 2'd3 || z_count !== 3'd1 || z_rd_valid !== 1'b1 || z_rd_pc !== 32'h20) begin
            tests_failed++;
            $display("FAIL post0_trigger: state=%0d count=%0d rd_valid=%b rd_pc=%h, want 3 1 1 00000020",
                     z_state, z_count, z_rd_valid, z_rd_pc);
        end
        tests_run++;
        if (state !== 2'd2 || count !== 3'd1) begin
            tests_failed++;
            $display("FAIL post2_trigger: state=%0d count=%0d, want 2 1", state, count);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        tests_run++;
        if (z_rd_valid !== 1'b0 || z_count !== 3'd0 || z_state !== 2'd3) begin
            tests_failed++;
            $display("FAIL post0_drain: rd_valid=%b count=%0d state=%0d, want 0 0 3", z_rd_valid, z_count, z_state);
        end
    endtask

    task automatic test_arm_priority();
        arm = 1'b1;
        capture(32'h20, 1'b1, 1'b1);
        arm = 1'b0;
        tests_run++;
        if (state !== 2'd1 || count !== 3'd0 || z_state !== 2'd1 || z_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL arm_priority: state=%0d count=%0d z_state=%0d z_count=%0d, want 1 0 1 0",
                     state, count, z_state, z_count);
        end
        capture(32'h30, 1'b1, 1'b0);
        tests_run++;
        if (state !== 2'd1 || count !== 3'd1) begin
            tests_failed++;
            $display("FAIL armed_capture: state=%0d count=%0d, want 1 1", state, count);
        end
    endtask

    task automatic test_wb_filter();
        logic [31:0] exp_pc [3];
`ifdef PIPE_TRACE_WB_FILTER_EN
        exp_pc = '{32'h40, 32'h44, 32'h48};
`else
        exp_pc = '{32'h40, 32'h42, 32'h44};
`endif
        trig_pc = 32'hFFFF;
        do_arm();
        for (int i = 0; i < 6; i++) capture(32'h40 + 32'(2 * i), (i % 2) == 0, i == 0);
        tests_run++;
        if (state !== 2'd3 || count !== 3'd3 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL wb_filter_frozen: state=%0d count=%0d ovf=%b, want 3 3 0", state, count, overflow);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rd_valid !== 1'b1 || rd_pc !== exp_pc[i]) begin
                tests_failed++;
                $display("FAIL wb_filter_read[%0d]: rd_valid=%b rd_pc=%h, want 1 %h", i, rd_valid, rd_pc, exp_pc[i]);
            end
            tick();
        end
        rd_ready = 1'b0;
        tests_run++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL wb_filter_drained: rd_valid=%b count=%0d, want 0 0", rd_valid, count);
        end
    endtask

    initial begin
        #12 rst = 1'b1;
        tick();
        test_reset();
        test_capture_overflow();
        test_read_stall();
        test_readout_order();
        test_reset_mid_frozen();
        test_trigger_first();
        test_arm_priority();
        test_wb_filter();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
